// File: rtl/cpu_defs_pkg.sv
// ---------------------------------------------------------------------------
// cpu_defs
//   Core-wide constants shared by the fetch stage, CP0 and later pipeline
//   stages: reset/exception vectors, the legal instruction-memory window and
//   the ExcCode values used on the pipeline exception fields.
// ---------------------------------------------------------------------------
package cpu_defs;

  localparam logic [31:0] PC_RESET  = 32'h0000_3000;
  localparam logic [31:0] EXC_ENTRY = 32'h0000_4180;
  localparam logic [31:0] IM_BASE   = 32'h0000_3000;
  localparam logic [31:0] IM_LIMIT  = 32'h0000_6FFC;

  localparam logic [4:0]  EXC_NONE  = 5'd0;
  localparam logic [4:0]  EXC_ADEL  = 5'd4;

endpackage : cpu_defs

// File: rtl/fetch_addr_check.sv
// ---------------------------------------------------------------------------
// fetch_addr_check
//   Pure combinational address-error detector. Flags a word address that is
//   misaligned or outside the inclusive window [BASE, LIMIT]. Also used by
//   the data-side address checks, so the window is parameterised.
// Ports
//   i_addr  in  32  address to check
//   o_adel  out 1   1 = address error
// ---------------------------------------------------------------------------
module fetch_addr_check
  import cpu_defs::*;
#(
  parameter logic [31:0] BASE  = IM_BASE,
  parameter logic [31:0] LIMIT = IM_LIMIT
) (
  input  logic [31:0] i_addr,
  output logic        o_adel
);

  logic w_misaligned;
  logic w_below;
  logic w_above;

  // Unsigned compares: addresses are never treated as signed.
  assign w_misaligned = (i_addr[1:0] != 2'b00);
  assign w_below      = (i_addr < BASE);
  assign w_above      = (i_addr > LIMIT);

  assign o_adel = w_misaligned | w_below | w_above;

endmodule : fetch_addr_check

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage: owns the PC register, drives instruction memory
//   and produces the F-side fields for the F/D pipeline register. Selects the
//   next PC among exception entry, ERET return, D-stage branch/jump and
//   sequential fetch, and raises AdEL on illegal fetch addresses.
// Ports
//   clk              in   1   clock, rising edge
//   reset            in   1   synchronous, active-high reset
//   stall            in   1   hazard-unit stall; PC holds
//   exc_req          in   1   CP0 exception/interrupt taken this cycle
//   eret_D           in   1   ERET decoded in D
//   epc              in   32  ERET return target
//   branch_taken_D   in   1   D-stage branch/jump taken
//   branch_target_D  in   32  D-stage branch/jump target
//   is_jump_D        in   1   D instruction is a branch/jump
//   instr_i          in   32  IM read data at im_addr_o
//   im_addr_o        out  32  IM read address (= pc_F)
//   pc_F             out  32  current fetch PC
//   InstrF           out  32  fetched instruction (nop on AdEL)
//   PC_4F            out  32  pc_F + 4
//   ExcCodeF         out  5   0 = none, 4 = AdEL
//   if_bdF           out  1   fetched instruction is a delay slot
//   kill_F           out  1   fetched instruction is wrong-path (after ERET)
// ---------------------------------------------------------------------------
module fetch_stage
  import cpu_defs::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        exc_req,
  input  logic        eret_D,
  input  logic [31:0] epc,
  input  logic        branch_taken_D,
  input  logic [31:0] branch_target_D,
  input  logic        is_jump_D,
  input  logic [31:0] instr_i,
  output logic [31:0] im_addr_o,
  output logic [31:0] pc_F,
  output logic [31:0] InstrF,
  output logic [31:0] PC_4F,
  output logic [4:0]  ExcCodeF,
  output logic        if_bdF,
  output logic        kill_F
);

  logic [31:0] r_pc;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_pc_next;
  logic        w_adel;

  // Wraps modulo 2^32; no saturation.
  assign w_pc_plus4 = r_pc + 32'd4;

  // Exception entry beats stall: CP0 flushes the whole pipe, so holding F
  // would only delay the handler.
  always_comb begin
    w_pc_next = w_pc_plus4;
    if (exc_req)             w_pc_next = EXC_ENTRY;
    else if (stall)          w_pc_next = r_pc;
    else if (eret_D)         w_pc_next = epc;
    else if (branch_taken_D) w_pc_next = branch_target_D;
  end

  // Redirect targets are loaded unchanged even if illegal; the address
  // error is raised when that PC is actually fetched.
  always_ff @(posedge clk) begin
    if (reset) r_pc <= PC_RESET;
    else       r_pc <= w_pc_next;
  end

  fetch_addr_check #(
    .BASE  (IM_BASE),
    .LIMIT (IM_LIMIT)
  ) u_addr_check (
    .i_addr (r_pc),
    .o_adel (w_adel)
  );

  assign im_addr_o = r_pc;
  assign pc_F      = r_pc;
  assign PC_4F     = w_pc_plus4;
  assign InstrF    = w_adel ? 32'h0000_0000 : instr_i;
  assign ExcCodeF  = w_adel ? EXC_ADEL : EXC_NONE;

  // D holds during a stall, so the delay-slot flag stays valid then too.
  assign if_bdF    = is_jump_D;

  // ERET has no delay slot: squash the instruction fetched behind it, unless
  // the ERET is not advancing (stall) or CP0 is flushing everything anyway.
  assign kill_F    = eret_D & ~stall & ~exc_req;

endmodule : fetch_stage
